// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared encodings and widths for the writeback stage
package mem_wb_pkg;

   localparam int DEF_XLEN = 64;

   localparam logic [2:0] LOAD_LB     = 3'b000;
   localparam logic [2:0] LOAD_LH     = 3'b001;
   localparam logic [2:0] LOAD_LW     = 3'b010;
   localparam logic [2:0] LOAD_LD     = 3'b011;
   localparam logic [2:0] LOAD_LBU    = 3'b100;
   localparam logic [2:0] LOAD_LHU    = 3'b101;
   localparam logic [2:0] LOAD_LWU    = 3'b110;
   localparam logic [2:0] LOAD_LD_ALT = 3'b111;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_LOAD = 2'b01;
   localparam logic [1:0] WB_SEL_PC4  = 2'b10;
   localparam logic [1:0] WB_SEL_ALU2 = 2'b11;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } wb_state_e;

endpackage

// File: rtl/mem_wb_load_ext.sv
// rtl/mem_wb_load_ext.sv - sign/zero extension of bit-0 aligned load data
module mem_wb_load_ext
   import mem_wb_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic [XLEN-1:0] data_i,
   input  logic [2:0]      load_type_i,
   output logic [XLEN-1:0] data_o
);

   always_comb begin
      data_o = data_i;
      case (load_type_i)
         LOAD_LB:     data_o = {{(XLEN-8){data_i[7]}}, data_i[7:0]};
         LOAD_LH:     data_o = {{(XLEN-16){data_i[15]}}, data_i[15:0]};
         LOAD_LW:     data_o = {{(XLEN-32){data_i[31]}}, data_i[31:0]};
         LOAD_LBU:    data_o = {{(XLEN-8){1'b0}}, data_i[7:0]};
         LOAD_LHU:    data_o = {{(XLEN-16){1'b0}}, data_i[15:0]};
         LOAD_LWU:    data_o = {{(XLEN-32){1'b0}}, data_i[31:0]};
         LOAD_LD,
         LOAD_LD_ALT: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/mem_wb.sv
// rtl/mem_wb.sv - writeback stage: register-file write, forwarding, instret, ebreak halt
module mem_wb
   import mem_wb_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int CNT_W = 64
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             m_valid,
   output logic             m_ready,
   input  logic [XLEN-1:0]  m_data,
   input  logic [1:0]       m_wb_select,
   input  logic [2:0]       m_load_type,
   input  logic [4:0]       m_rd,
   input  logic             m_reg_we,
   input  logic             m_ebreak,
   input  logic [XLEN-1:0]  m_pc,
   input  logic             flush,
   input  logic             hold,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             fwd_valid,
   output logic [4:0]       fwd_rd,
   output logic [XLEN-1:0]  fwd_data,
   output logic [CNT_W-1:0] instret,
   output logic             halted,
   output logic [XLEN-1:0]  halt_pc
);

   wb_state_e        state_q, state_d;
   logic             w_valid_q, w_valid_d;
   logic [4:0]       w_rd_q, w_rd_d;
   logic             w_we_q, w_we_d;
   logic [XLEN-1:0]  w_data_q, w_data_d;
   logic [XLEN-1:0]  w_pc_q, w_pc_d;
   logic             w_ebreak_q, w_ebreak_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [XLEN-1:0]  halt_pc_q, halt_pc_d;

   logic [XLEN-1:0]  ext_data;
   logic [XLEN-1:0]  cap_data;
   logic             run, accept, retire;

   mem_wb_load_ext #(.XLEN(XLEN)) u_load_ext (
      .data_i      (m_data),
      .load_type_i (m_load_type),
      .data_o      (ext_data)
   );

   always_comb begin
      cap_data = m_data;
      case (m_wb_select)
         WB_SEL_LOAD:                         cap_data = ext_data;
         WB_SEL_ALU, WB_SEL_PC4, WB_SEL_ALU2: cap_data = m_data;
      endcase
   end

   // A retiring ebreak blocks the next offer so nothing follows it into W.
   assign run     = (state_q == ST_RUN);
   assign m_ready = run & ~hold & ~(w_valid_q & w_ebreak_q);
   assign accept  = m_valid & m_ready & ~flush;
   assign retire  = w_valid_q & ~hold & run;

   assign rf_we     = retire & w_we_q & (w_rd_q != 5'd0);
   assign rf_waddr  = w_rd_q;
   assign rf_wdata  = w_data_q;
   assign fwd_valid = rf_we;
   assign fwd_rd    = w_rd_q;
   assign fwd_data  = w_data_q;
   assign instret   = instret_q;
   assign halted    = (state_q == ST_HALTED);
   assign halt_pc   = halt_pc_q;

   always_comb begin
      state_d    = state_q;
      w_valid_d  = w_valid_q;
      w_rd_d     = w_rd_q;
      w_we_d     = w_we_q;
      w_data_d   = w_data_q;
      w_pc_d     = w_pc_q;
      w_ebreak_d = w_ebreak_q;
      instret_d  = instret_q;
      halt_pc_d  = halt_pc_q;
      if (run && !hold) begin
         w_valid_d = accept;
         if (accept) begin
            w_rd_d     = m_rd;
            w_we_d     = m_reg_we;
            w_data_d   = cap_data;
            w_pc_d     = m_pc;
            w_ebreak_d = m_ebreak;
         end
      end
      if (retire) begin
         instret_d = instret_q + CNT_W'(1);
         if (w_ebreak_q) begin
            state_d   = ST_HALTED;
            halt_pc_d = w_pc_q;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q    <= ST_RUN;
         w_valid_q  <= 1'b0;
         w_rd_q     <= '0;
         w_we_q     <= 1'b0;
         w_data_q   <= '0;
         w_pc_q     <= '0;
         w_ebreak_q <= 1'b0;
         instret_q  <= '0;
         halt_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         w_valid_q  <= w_valid_d;
         w_rd_q     <= w_rd_d;
         w_we_q     <= w_we_d;
         w_data_q   <= w_data_d;
         w_pc_q     <= w_pc_d;
         w_ebreak_q <= w_ebreak_d;
         instret_q  <= instret_d;
         halt_pc_q  <= halt_pc_d;
      end
   end

endmodule

// File: tb/tb_mem_wb.sv
// tb/tb_mem_wb.sv - self-checking bench for mem_wb
module tb_mem_wb;

   localparam int XLEN  = 64;
   localparam int CNT_W = 64;

   logic             sys_clk = 1'b0;
   logic             sys_rst;
   logic             m_valid;
   logic             m_ready;
   logic [XLEN-1:0]  m_data;
   logic [1:0]       m_wb_select;
   logic [2:0]       m_load_type;
   logic [4:0]       m_rd;
   logic             m_reg_we;
   logic             m_ebreak;
   logic [XLEN-1:0]  m_pc;
   logic             flush;
   logic             hold;
   logic             rf_we;
   logic [4:0]       rf_waddr;
   logic [XLEN-1:0]  rf_wdata;
   logic             fwd_valid;
   logic [4:0]       fwd_rd;
   logic [XLEN-1:0]  fwd_data;
   logic [CNT_W-1:0] instret;
   logic             halted;
   logic [XLEN-1:0]  halt_pc;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] exp_instret = 64'd0;

   mem_wb #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_wb_select(m_wb_select), .m_load_type(m_load_type),
      .m_rd(m_rd), .m_reg_we(m_reg_we), .m_ebreak(m_ebreak), .m_pc(m_pc),
      .flush(flush), .hold(hold),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .instret(instret), .halted(halted), .halt_pc(halt_pc)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Load result from the ISA meaning: keep the low n bits, then subtract 2^n if signed and negative.
   function automatic logic [63:0] ref_ext(input logic [63:0] d, input logic [1:0] sel,
                                           input logic [2:0] lt);
      int          n;
      logic        sgn;
      logic [63:0] v;
      if (sel != 2'b01) return d;
      case (lt)
         3'd0, 3'd4: n = 8;
         3'd1, 3'd5: n = 16;
         3'd2, 3'd6: n = 32;
         default:    n = 64;
      endcase
      if (n == 64) return d;
      sgn = (lt < 3'd3);
      v = d & ((64'd1 << n) - 64'd1);
      if (sgn && d[n-1]) v = v - (64'd1 << n);
      return v;
   endfunction

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic idle();
      m_valid = 1'b0;
      flush   = 1'b0;
      hold    = 1'b0;
   endtask

   task automatic offer(input logic [63:0] d, input logic [1:0] sel, input logic [2:0] lt,
                        input logic [4:0] rd, input logic we, input logic eb,
                        input logic [63:0] pc);
      m_valid     = 1'b1;
      m_data      = d;
      m_wb_select = sel;
      m_load_type = lt;
      m_rd        = rd;
      m_reg_we    = we;
      m_ebreak    = eb;
      m_pc        = pc;
   endtask

   task automatic test_reset();
      sys_rst = 1'b0;
      idle();
      offer(64'h0, 2'b00, 3'b000, 5'd0, 1'b0, 1'b0, 64'h0);
      m_valid = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      checks++;
      if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 64'd0 ||
          fwd_rd !== 5'd0 || fwd_data !== 64'd0)
         begin errors++; $display("FAIL reset_wport: rf_we=%b fwd_valid=%b rf_waddr=%0d rf_wdata=%h, required all zero", rf_we, fwd_valid, rf_waddr, rf_wdata); end
      checks++;
      if (instret !== 64'd0 || halted !== 1'b0 || halt_pc !== 64'd0)
         begin errors++; $display("FAIL reset_state: instret=%0d halted=%b halt_pc=%h, required 0", instret, halted, halt_pc); end
      checks++;
      if (m_ready !== 1'b1)
         begin errors++; $display("FAIL reset_ready: m_ready=%b, required 1", m_ready); end
      #2 sys_rst = 1'b1;
      step();
   endtask

   task automatic test_lb_sign();
      offer(64'h0000_0000_0000_0080, 2'b01, 3'b000, 5'd5, 1'b1, 1'b0, 64'h100);
      step();
      idle();
      #1;
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'hFFFF_FFFF_FFFF_FF80 ||
          fwd_valid !== 1'b1 || fwd_data !== 64'hFFFF_FFFF_FFFF_FF80)
         begin errors++; $display("FAIL lb_sign: rf_we=%b waddr=%0d wdata=%h, required 1/5/ffffffffffffff80", rf_we, rf_waddr, rf_wdata); end
      step();
      exp_instret = exp_instret + 1;
      checks++;
      if (instret !== exp_instret || rf_we !== 1'b0)
         begin errors++; $display("FAIL lb_instret: instret=%0d rf_we=%b, required %0d/0", instret, rf_we, exp_instret); end
   endtask

   task automatic test_zero_ext_x0();
      offer(64'hDEAD_BEEF_1234_8001, 2'b01, 3'b101, 5'd7, 1'b1, 1'b0, 64'h104);
      step();
      offer(64'h55, 2'b00, 3'b000, 5'd0, 1'b1, 1'b0, 64'h108);
      #1;
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 64'h8001)
         begin errors++; $display("FAIL lhu_zero: rf_we=%b waddr=%0d wdata=%h, required 1/7/8001", rf_we, rf_waddr, rf_wdata); end
      step();
      idle();
      #1;
      checks++;
      if (rf_we !== 1'b0 || fwd_valid !== 1'b0)
         begin errors++; $display("FAIL x0_write: rf_we=%b fwd_valid=%b, required 0", rf_we, fwd_valid); end
      step();
      exp_instret = exp_instret + 2;
      checks++;
      if (instret !== exp_instret)
         begin errors++; $display("FAIL x0_instret: instret=%0d, required %0d", instret, exp_instret); end
   endtask

   task automatic test_hold();
      offer(64'h1234, 2'b00, 3'b011, 5'd9, 1'b1, 1'b0, 64'h200);
      step();
      offer(64'h5555, 2'b00, 3'b011, 5'd10, 1'b1, 1'b0, 64'h204);
      for (int i = 0; i < 3; i++) begin
         hold = 1'b1;
         #1;
         checks++;
         if (m_ready !== 1'b0 || rf_we !== 1'b0 || instret !== exp_instret)
            begin errors++; $display("FAIL hold_freeze[%0d]: m_ready=%b rf_we=%b instret=%0d, required 0/0/%0d", i, m_ready, rf_we, instret, exp_instret); end
         step();
      end
      idle();
      #1;
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 64'h1234)
         begin errors++; $display("FAIL hold_release: rf_we=%b waddr=%0d wdata=%h, required 1/9/1234", rf_we, rf_waddr, rf_wdata); end
      step();
      exp_instret = exp_instret + 1;
      checks++;
      if (rf_we !== 1'b0 || instret !== exp_instret)
         begin errors++; $display("FAIL hold_once: rf_we=%b instret=%0d, required 0/%0d", rf_we, instret, exp_instret); end
   endtask

   task automatic test_flush();
      offer(64'hAAAA, 2'b00, 3'b000, 5'd11, 1'b1, 1'b0, 64'h300);
      step();
      offer(64'hBBBB, 2'b00, 3'b000, 5'd12, 1'b1, 1'b0, 64'h304);
      flush = 1'b1;
      #1;
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 64'hAAAA)
         begin errors++; $display("FAIL flush_inflight: rf_we=%b waddr=%0d wdata=%h, required 1/11/aaaa", rf_we, rf_waddr, rf_wdata); end
      step();
      idle();
      #1;
      checks++;
      if (rf_we !== 1'b0)
         begin errors++; $display("FAIL flush_drop: rf_we=%b waddr=%0d, required 0", rf_we, rf_waddr); end
      step();
      exp_instret = exp_instret + 1;
      checks++;
      if (instret !== exp_instret)
         begin errors++; $display("FAIL flush_instret: instret=%0d, required %0d", instret, exp_instret); end
   endtask

   task automatic test_ebreak();
      offer(64'h77, 2'b10, 3'b000, 5'd14, 1'b1, 1'b0, 64'h8000_000C);
      step();
      offer(64'h0, 2'b00, 3'b000, 5'd0, 1'b0, 1'b1, 64'h8000_0010);
      #1;
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd14 || rf_wdata !== 64'h77)
         begin errors++; $display("FAIL b2b_write: rf_we=%b waddr=%0d wdata=%h, required 1/14/77", rf_we, rf_waddr, rf_wdata); end
      step();
      offer(64'h99, 2'b00, 3'b000, 5'd13, 1'b1, 1'b0, 64'h8000_0014);
      #1;
      checks++;
      if (m_ready !== 1'b0 || rf_we !== 1'b0)
         begin errors++; $display("FAIL ebreak_retire: m_ready=%b rf_we=%b, required 0/0", m_ready, rf_we); end
      step();
      exp_instret = exp_instret + 2;
      checks++;
      if (halted !== 1'b1 || halt_pc !== 64'h8000_0010 || instret !== exp_instret)
         begin errors++; $display("FAIL ebreak_halt: halted=%b halt_pc=%h instret=%0d, required 1/80000010/%0d", halted, halt_pc, instret, exp_instret); end
      for (int i = 0; i < 10; i++) begin
         offer({$urandom, $urandom}, 2'($urandom), 3'($urandom), 5'($urandom | 1), 1'b1, 1'b0, 64'h400);
         hold  = 1'($urandom);
         flush = 1'($urandom);
         #1;
         checks++;
         if (m_ready !== 1'b0 || rf_we !== 1'b0 || halted !== 1'b1 || instret !== exp_instret)
            begin errors++; $display("FAIL halted_idle[%0d]: m_ready=%b rf_we=%b halted=%b instret=%0d", i, m_ready, rf_we, halted, instret); end
         step();
      end
      idle();
   endtask

   task automatic test_async_reset();
      #2 sys_rst = 1'b0;
      #1;
      checks++;
      if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 64'd0 ||
          instret !== 64'd0 || halted !== 1'b0 || halt_pc !== 64'd0)
         begin errors++; $display("FAIL async_reset: rf_we=%b wdata=%h instret=%0d halted=%b halt_pc=%h, required all zero", rf_we, rf_wdata, instret, halted, halt_pc); end
      #2 sys_rst = 1'b1;
      exp_instret = 64'd0;
      step();
      offer(64'hABCD_0123_8000_0000, 2'b01, 3'b010, 5'd20, 1'b1, 1'b0, 64'h500);
      #1;
      checks++;
      if (m_ready !== 1'b1)
         begin errors++; $display("FAIL post_reset_ready: m_ready=%b, required 1", m_ready); end
      step();
      idle();
      #1;
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd20 || rf_wdata !== 64'hFFFF_FFFF_8000_0000)
         begin errors++; $display("FAIL post_reset_lw: rf_we=%b waddr=%0d wdata=%h, required 1/20/ffffffff80000000", rf_we, rf_waddr, rf_wdata); end
      step();
      exp_instret = exp_instret + 1;
      checks++;
      if (instret !== exp_instret)
         begin errors++; $display("FAIL post_reset_instret: instret=%0d, required %0d", instret, exp_instret); end
   endtask

   task automatic test_random();
      logic        pend_v = 1'b0;
      logic [4:0]  pend_rd = '0;
      logic        pend_we = 1'b0;
      logic [63:0] pend_data = '0;
      logic        exp_we;
      for (int i = 0; i < 300; i++) begin
         offer({$urandom, $urandom}, 2'($urandom), 3'($urandom), 5'($urandom),
               1'($urandom), 1'b0, {$urandom, $urandom});
         m_valid = ($urandom_range(0, 3) != 0);
         hold    = ($urandom_range(0, 7) == 0);
         flush   = ($urandom_range(0, 7) == 0);
         #1;
         exp_we = pend_v && !hold && pend_we && (pend_rd != 5'd0);
         checks++;
         if (rf_we !== exp_we || fwd_valid !== exp_we ||
             (exp_we && (rf_waddr !== pend_rd || rf_wdata !== pend_data ||
                         fwd_rd !== pend_rd || fwd_data !== pend_data)))
            begin errors++; $display("FAIL rand_write[%0d]: rf_we=%b waddr=%0d wdata=%h, required %b/%0d/%h", i, rf_we, rf_waddr, rf_wdata, exp_we, pend_rd, pend_data); end
         checks++;
         if (m_ready !== !hold)
            begin errors++; $display("FAIL rand_ready[%0d]: m_ready=%b, required %b", i, m_ready, !hold); end
         checks++;
         if (instret !== exp_instret)
            begin errors++; $display("FAIL rand_instret[%0d]: instret=%0d, required %0d", i, instret, exp_instret); end
         if (!hold) begin
            if (pend_v) exp_instret = exp_instret + 1;
            pend_v    = m_valid && !flush;
            pend_rd   = m_rd;
            pend_we   = m_reg_we;
            pend_data = ref_ext(m_data, m_wb_select, m_load_type);
         end
         step();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_lb_sign();
      test_zero_ext_x0();
      test_hold();
      test_flush();
      test_ebreak();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_wb.md
Name: mem_wb

Overview:
- Writeback stage directly downstream of the memory stage.
- Captures the memory stage's selected result: ALU result, pc+4, or the raw load data shifted down by byte offset.
- Applies load sign/zero extension and drives the register-file write port and the forwarding bus.
- Counts retired instructions and enters a terminal halt state when an ebreak retires.

Parameters:
XLEN, 64, datapath width
CNT_W, 64, width of retired-instruction counter

Ports:
sys_clk  in  1  clock, all state on rising edge
sys_rst  in  1  asynchronous, active-low reset
m_valid  in  1  memory stage presents an instruction this cycle
m_ready  out  1  stage accepts the instruction this cycle
m_data  in  XLEN  memory-stage result after its wb_select mux; load data already shifted to bit 0
m_wb_select  in  2  00 alu, 01 load, 10 pc+4, 11 alu
m_load_type  in  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 treated as LD
m_rd  in  5  destination register
m_reg_we  in  1  instruction writes rd
m_ebreak  in  1  instruction is ebreak
m_pc  in  XLEN  instruction pc
flush  in  1  kill the instruction offered this cycle
hold  in  1  freeze stage (debug / external stall)
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  XLEN  register-file write data
fwd_valid  out  1  forwarding bus valid; equals rf_we
fwd_rd  out  5  forwarding register
fwd_data  out  XLEN  forwarding data
instret  out  CNT_W  retired-instruction count
halted  out  1  ebreak has retired
halt_pc  out  XLEN  pc of the retired ebreak

Behaviour:
- Stage register W holds: w_valid, w_rd, w_we, w_data, w_pc, w_ebreak.
- FSM has two states, RUN and HALTED.
- Reset (sys_rst=0, asynchronous):
  - state=RUN, w_valid=0, all W fields=0.
  - instret=0, halted=0, halt_pc=0.
  - Every output is 0 except m_ready, which is combinational.
- m_ready = (state==RUN) & ~hold & ~(w_valid & w_ebreak). This is combinational. An instruction offered in the same cycle an ebreak retires is not accepted.
- Accept = m_valid & m_ready & ~flush.
- Extension (combinational on m_data, applied at capture):
  - m_wb_select==01: LB/LH/LW sign-extend bits 7/15/31; LBU/LHU/LWU zero-extend; LD/111 pass all 64 bits.
  - Any other m_wb_select: m_data passes unchanged and m_load_type is ignored.
- W update, when ~hold and state==RUN:
  - Accept: W <= captured fields, w_valid=1.
  - Otherwise: w_valid <= 0; other fields are don't-care.
  - Latency from accept to rf_we is 1 cycle.
- hold=1: W is frozen. The retire event is suppressed, so rf_we=0, fwd_valid=0 and instret does not increment. When hold falls, the held instruction retires exactly once.
- flush: takes priority over m_valid and only drops the offered instruction. An instruction already in W still retires. flush is ignored in HALTED.
- Retire = w_valid & ~hold & (state==RUN).
  - rf_we = retire & w_we & (w_rd!=0). rf_waddr=w_rd, rf_wdata=w_data.
  - fwd_* mirror rf_*; fwd_valid=0 whenever rf_we=0.
  - instret += 1 on every retire, including rd=x0 and ebreak. Wraps modulo 2^CNT_W.
- On a retire with w_ebreak=1, in the next cycle:
  - state -> HALTED, halted=1, halt_pc=w_pc, w_valid=0.
  - The ebreak's own rf_we follows w_we and is normally 0.
- HALTED:
  - m_ready=0 and rf_we=0.
  - hold and flush are ignored.
  - Left only by reset.
- Reset mid-hold or mid-halt returns to RUN with an empty stage.

Decomposition:
- Shared package, in the existing para.v style: LOAD_* type encodings, WB_SEL_* encodings, ST_RUN/ST_HALTED constants, XLEN width macro.
- One natural sub-module: load_ext. It is combinational, taking m_data and load type and returning the extended XLEN value, and is reusable by a future cache path.

Test Plan:
- LB sign extension: m_wb_select=01, LB, m_data=0x...00000080, rd=5, we=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xFFFFFFFFFFFFFF80, instret=1.
- Zero extension and x0: LHU data 0x...0000_8001 -> rf_wdata=0x8001. Then rd=0 with we=1 -> rf_we=0, but instret increments.
- hold: valid ALU result 0x1234 accepted, then hold=1 for 3 cycles with m_valid=1 -> m_ready=0, rf_we=0 throughout. After hold drops, exactly one write of 0x1234 and instret +1.
- flush priority: m_valid=1, flush=1 -> next cycle rf_we=0 and instret unchanged. An instruction already in W in that cycle still writes.
- ebreak: accept ebreak at pc=0x80000010 while the next instruction waits -> m_ready=0 in the ebreak retire cycle. Next cycle halted=1, halt_pc=0x80000010. Further m_valid is ignored for 10 cycles and rf_we stays 0.
- Async reset: drop sys_rst between clock edges while halted with instret=7 -> all outputs 0 immediately. After release, a normal load retires correctly.
